// File: rtl/cpc_write_fifo.sv
// CPC write-strobe capture FIFO with a 4-phase READY/ACK handshake towards the ATMega.
// Optional sticky overrun flag: define OVERRUN_FLAG_EN.
module cpc_write_fifo #(
  parameter int unsigned DEPTH_LOG2  = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  iCLK,
  input  logic                  i_RESET,
  input  logic                  iWRITE_STB,
  input  logic [7:0]            iCPC_BYTE,
  input  logic                  iATMEGA_ACK,
  output logic [7:0]            oATMEGA_DATA,
  output logic                  oDATA_READY,
  output logic                  oFIFO_FULL,
`ifdef OVERRUN_FLAG_EN
  output logic                  oOVERRUN,
`endif
  output logic [DEPTH_LOG2:0]   oLEVEL
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;
  localparam int unsigned PW    = DEPTH_LOG2;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_LOAD     = 2'd1,
    ST_PRESENT  = 2'd2,
    ST_WAIT_REL = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_stb_sync;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic                   r_stb_edge;
  logic                   r_ack_edge;
  logic                   w_push;
  logic                   w_ack_rise;
  logic                   w_ack_lvl;

  logic [7:0]             r_mem [DEPTH];
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [LW-1:0]          r_level;
  logic [LW-1:0]          w_level_nxt;
  logic                   r_full;
  logic                   w_pop;
  logic                   w_wr;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_ready_nxt;
  logic                   w_load;
  logic                   r_ready;
  logic [7:0]             r_data;

  // Synchronisers preset high so a level held across reset release is not an edge
  always_ff @(posedge iCLK or negedge i_RESET) begin
    if (!i_RESET) begin
      r_stb_sync <= '1;
      r_ack_sync <= '1;
      r_stb_edge <= 1'b1;
      r_ack_edge <= 1'b1;
    end else begin
      r_stb_sync <= {r_stb_sync[SYNC_STAGES-2:0], iWRITE_STB};
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], iATMEGA_ACK};
      r_stb_edge <= r_stb_sync[SYNC_STAGES-1];
      r_ack_edge <= r_ack_sync[SYNC_STAGES-1];
    end
  end

  assign w_push     = r_stb_sync[SYNC_STAGES-1] & ~r_stb_edge;
  assign w_ack_rise = r_ack_sync[SYNC_STAGES-1] & ~r_ack_edge;
  assign w_ack_lvl  = r_ack_sync[SYNC_STAGES-1];

  // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle
  assign w_pop = w_ack_rise & (r_state == ST_PRESENT);
  assign w_wr  = w_push & (~r_full | w_pop);

  always_comb begin
    w_level_nxt = r_level;
    case ({w_wr, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge iCLK or negedge i_RESET) begin
    if (!i_RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LW'(DEPTH));
    end
  end

  always_ff @(posedge iCLK) begin
    if (w_wr) r_mem[r_wr_ptr] <= iCPC_BYTE;
  end

  // FSM state register
  always_ff @(posedge iCLK or negedge i_RESET) begin
    if (!i_RESET) r_state <= ST_EMPTY;
    else          r_state <= w_state_nxt;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY:    if (r_level != '0) w_state_nxt = ST_LOAD;
      ST_LOAD:     w_state_nxt = ST_PRESENT;
      ST_PRESENT:  if (w_ack_rise) w_state_nxt = ST_WAIT_REL;
      ST_WAIT_REL: if (!w_ack_lvl)
                     w_state_nxt = (r_level != '0) ? ST_LOAD : ST_EMPTY;
      default:     w_state_nxt = ST_EMPTY;
    endcase
  end

  // FSM outputs, registered below so READY rises together with entry to ST_PRESENT
  always_comb begin
    w_ready_nxt = 1'b0;
    w_load      = 1'b0;
    if (w_state_nxt == ST_PRESENT) w_ready_nxt = 1'b1;
    if (r_state == ST_LOAD)        w_load      = 1'b1;
  end

  always_ff @(posedge iCLK or negedge i_RESET) begin
    if (!i_RESET) begin
      r_ready <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      r_ready <= w_ready_nxt;
      if (w_load) r_data <= r_mem[r_rd_ptr];
    end
  end

`ifdef OVERRUN_FLAG_EN
  logic r_overrun;

  // Sticky until the byte that empties the FIFO is acknowledged
  always_ff @(posedge iCLK or negedge i_RESET) begin
    if (!i_RESET)                                r_overrun <= 1'b0;
    else if (w_push & r_full & ~w_pop)           r_overrun <= 1'b1;
    else if (w_pop && (r_level == LW'(1)))       r_overrun <= 1'b0;
  end

  assign oOVERRUN = r_overrun;
`endif

  assign oATMEGA_DATA = r_data;
  assign oDATA_READY  = r_ready;
  assign oFIFO_FULL   = r_full;
  assign oLEVEL       = r_level;

endmodule

// File: tb/tb_cpc_write_fifo.sv
// Self-checking bench for cpc_write_fifo: directed boundary cases plus a randomized phase
// against a queue-based model of the FIFO and handshake.
module tb_cpc_write_fifo;

  localparam int unsigned DEPTH = 8;

  logic       iCLK;
  logic       i_RESET;
  logic       iWRITE_STB;
  logic [7:0] iCPC_BYTE;
  logic       iATMEGA_ACK;
  logic [7:0] oATMEGA_DATA;
  logic       oDATA_READY;
  logic       oFIFO_FULL;
  logic [3:0] oLEVEL;
`ifdef OVERRUN_FLAG_EN
  logic       oOVERRUN;
`endif

  cpc_write_fifo dut (
    .iCLK         (iCLK),
    .i_RESET      (i_RESET),
    .iWRITE_STB   (iWRITE_STB),
    .iCPC_BYTE    (iCPC_BYTE),
    .iATMEGA_ACK  (iATMEGA_ACK),
    .oATMEGA_DATA (oATMEGA_DATA),
    .oDATA_READY  (oDATA_READY),
    .oFIFO_FULL   (oFIFO_FULL),
`ifdef OVERRUN_FLAG_EN
    .oOVERRUN     (oOVERRUN),
`endif
    .oLEVEL       (oLEVEL)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] q[$];
  logic       m_ovr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_level"}, 32'(oLEVEL), 32'(q.size()));
    check({tag, "_full"}, 32'(oFIFO_FULL), 32'(q.size() == DEPTH));
`ifdef OVERRUN_FLAG_EN
    check({tag, "_ovr"}, 32'(oOVERRUN), 32'(m_ovr));
`endif
  endtask

  task automatic strobe(input logic [7:0] b);
    @(negedge iCLK);
    iCPC_BYTE  = b;
    iWRITE_STB = 1'b1;
    repeat (2) @(negedge iCLK);
    iWRITE_STB = 1'b0;
    repeat (2) @(negedge iCLK);
    if (q.size() < DEPTH) q.push_back(b);
    else                  m_ovr = 1'b1;
  endtask

  task automatic wait_ready(input logic lvl, output logic ok);
    int n = 0;
    while (oDATA_READY !== lvl && n < 40) begin
      @(negedge iCLK);
      n++;
    end
    ok = (oDATA_READY === lvl);
    if (!ok) check("ready_timeout", 32'(oDATA_READY), 32'(lvl));
  endtask

  task automatic ack_one(input string tag);
    logic ok;
    wait_ready(1'b1, ok);
    if (!ok) return;
    check({tag, "_data"}, 32'(oATMEGA_DATA), 32'(q[0]));
    @(negedge iCLK);
    iATMEGA_ACK = 1'b1;
    wait_ready(1'b0, ok);
    if (q.size() == 1) m_ovr = 1'b0;
    void'(q.pop_front());
    iATMEGA_ACK = 1'b0;
    repeat (4) @(negedge iCLK);
    check_status(tag);
  endtask

  initial begin
    logic       ok;
    logic [7:0] b;
    i_RESET     = 1'b1;
    iWRITE_STB  = 1'b0;
    iCPC_BYTE   = 8'h00;
    iATMEGA_ACK = 1'b0;

    // 1: strobe and ACK high across reset release create no edges
    @(negedge iCLK);
    iWRITE_STB  = 1'b1;
    iATMEGA_ACK = 1'b1;
    i_RESET     = 1'b0;
    repeat (2) @(negedge iCLK);
    check("rst_data", 32'(oATMEGA_DATA), 32'h00);
    check("rst_ready", 32'(oDATA_READY), 32'd0);
    i_RESET = 1'b1;
    repeat (8) @(negedge iCLK);
    check("rel_ready", 32'(oDATA_READY), 32'd0);
    check_status("rel");
    iWRITE_STB  = 1'b0;
    iATMEGA_ACK = 1'b0;
    repeat (4) @(negedge iCLK);

    // 2: latency of a single byte and of the ACK response
    iCPC_BYTE  = 8'hA5;
    iWRITE_STB = 1'b1;
    repeat (4) @(posedge iCLK);
    #1 check("lat_early", 32'(oDATA_READY), 32'd0);
    @(posedge iCLK);
    #1 check("lat_ready", 32'(oDATA_READY), 32'd1);
    check("lat_data", 32'(oATMEGA_DATA), 32'hA5);
    @(negedge iCLK);
    iWRITE_STB  = 1'b0;
    repeat (2) @(negedge iCLK);
    iATMEGA_ACK = 1'b1;
    repeat (2) @(posedge iCLK);
    #1 check("ack_hold", 32'(oDATA_READY), 32'd1);
    @(posedge iCLK);
    #1 check("ack_drop", 32'(oDATA_READY), 32'd0);
    @(negedge iCLK);
    iATMEGA_ACK = 1'b0;
    repeat (5) @(negedge iCLK);
    check_status("single");

    // 3: fill to full, drain in order across pointer wrap
    for (int i = 1; i <= 8; i++) strobe(8'(i));
    check_status("fill");
    for (int i = 0; i < 8; i++) ack_one("drain");

    // 4: push while full is dropped
    for (int i = 0; i < 8; i++) strobe(8'(8'h10 + i));
    strobe(8'hFF);
    check_status("ovf");
    for (int i = 0; i < 8; i++) ack_one("ovf_drain");

    // 5: full FIFO, simultaneous push and pop keeps level at 8
    for (int i = 0; i < 8; i++) strobe(8'(8'h20 + i));
    wait_ready(1'b1, ok);
    check("simul_data", 32'(oATMEGA_DATA), 32'(q[0]));
    @(negedge iCLK);
    iCPC_BYTE   = 8'h5A;
    iWRITE_STB  = 1'b1;
    iATMEGA_ACK = 1'b1;
    void'(q.pop_front());
    q.push_back(8'h5A);
    repeat (2) @(negedge iCLK);
    iWRITE_STB = 1'b0;
    wait_ready(1'b0, ok);
    iATMEGA_ACK = 1'b0;
    repeat (4) @(negedge iCLK);
    check_status("simul");
    for (int i = 0; i < 8; i++) ack_one("simul_drain");

    // 6: asynchronous reset while presenting discards the FIFO
    strobe(8'h11);
    strobe(8'h22);
    strobe(8'h33);
    wait_ready(1'b1, ok);
    @(negedge iCLK);
    #2 i_RESET = 1'b0;
    #1;
    check("arst_ready", 32'(oDATA_READY), 32'd0);
    check("arst_data", 32'(oATMEGA_DATA), 32'h00);
    q.delete();
    m_ovr = 1'b0;
    check_status("arst");
    @(negedge iCLK);
    i_RESET = 1'b1;
    repeat (2) @(negedge iCLK);
    strobe(8'h3C);
    ack_one("fresh");
    check_status("fresh_end");

    // Randomized mix of pushes and acknowledges against the queue model
    for (int i = 0; i < 80; i++) begin
      if (q.size() != 0 && $urandom_range(0, 2) == 0) begin
        ack_one("rnd_ack");
      end else begin
        b = 8'($urandom);
        strobe(b);
        check_status("rnd_push");
      end
    end
    while (q.size() != 0) ack_one("rnd_drain");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
